// File: rtl/dma_pkg.sv
// Shared types for the DMA descriptor queue: descriptor layout, MMIO offsets, FSM states.
package dma_pkg;

  typedef struct packed {
    logic [63:0] src;
    logic [63:0] dst;
    logic [31:0] len;
  } desc_t;

  localparam logic [31:0] REG_SRC_LO   = 32'h10;
  localparam logic [31:0] REG_SRC_HI   = 32'h14;
  localparam logic [31:0] REG_DST_LO   = 32'h18;
  localparam logic [31:0] REG_DST_HI   = 32'h1C;
  localparam logic [31:0] REG_LEN      = 32'h20;
  localparam logic [31:0] REG_DOORBELL = 32'h24;
  localparam logic [31:0] REG_STATUS   = 32'h28;
  localparam logic [31:0] REG_DONE_CNT = 32'h2C;
  localparam logic [31:0] REG_CTRL     = 32'h30;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT
  } state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead read data; a push into a full FIFO is accepted
// when a pop happens in the same cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/dma_desc_queue.sv
// MMIO-programmed descriptor queue feeding a DMA engine one descriptor at a time,
// with completion counting and a level interrupt.
module dma_desc_queue
  import dma_pkg::*;
#(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned ADDR_WIDTH = 48
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cfg_req_valid,
  input  logic        cfg_req_write,
  input  logic [31:0] cfg_req_addr,
  input  logic [31:0] cfg_req_wdata,
  output logic        cfg_resp_valid,
  output logic [31:0] cfg_resp_rdata,
  output logic        dma_start,
  output logic [63:0] dma_src_addr,
  output logic [63:0] dma_dst_addr,
  output logic [31:0] dma_len,
  input  logic        dma_done,
  output logic        irq
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [63:0] ADDR_MASK =
    (ADDR_WIDTH >= 64) ? {64{1'b1}} : ((64'd1 << ADDR_WIDTH) - 64'd1);

  logic [31:0]   src_lo, src_hi, dst_lo, dst_hi, len_q;
  logic [31:0]   done_cnt;
  logic          irq_en;
  logic          overflow;
  state_t        state, state_nxt;
  desc_t         push_desc, head_desc, out_desc;
  logic          fifo_pop, fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  logic          wr_en, rd_en, doorbell, done_clr, done_inc, load_out;
  logic [31:0]   rdata_nxt;

  assign wr_en    = cfg_req_valid && cfg_req_write;
  assign rd_en    = cfg_req_valid && !cfg_req_write;
  assign doorbell = wr_en && (cfg_req_addr == REG_DOORBELL);
  assign done_clr = wr_en && (cfg_req_addr == REG_DONE_CNT);

  always_comb begin
    push_desc     = '0;
    push_desc.src = {src_hi, src_lo} & ADDR_MASK;
    push_desc.dst = {dst_hi, dst_lo} & ADDR_MASK;
    push_desc.len = len_q;
  end

  sync_fifo #(
    .WIDTH($bits(desc_t)),
    .DEPTH(DEPTH),
    .CW   (CW)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (doorbell),
    .wdata(push_desc),
    .pop  (fifo_pop),
    .rdata(head_desc),
    .full (fifo_full),
    .empty(fifo_empty),
    .count(fifo_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Zero-length descriptors are retired straight out of IDLE without touching the engine.
  always_comb begin
    state_nxt = state;
    fifo_pop  = 1'b0;
    load_out  = 1'b0;
    done_inc  = 1'b0;
    dma_start = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          if (head_desc.len == '0) begin
            done_inc = 1'b1;
          end else begin
            load_out  = 1'b1;
            state_nxt = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        dma_start = 1'b1;
        state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (dma_done) begin
          done_inc  = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        out_desc <= '0;
    else if (load_out) out_desc <= head_desc;
  end

  assign dma_src_addr = out_desc.src;
  assign dma_dst_addr = out_desc.dst;
  assign dma_len      = out_desc.len;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_lo <= '0;
      src_hi <= '0;
      dst_lo <= '0;
      dst_hi <= '0;
      len_q  <= '0;
      irq_en <= 1'b0;
    end else if (wr_en) begin
      case (cfg_req_addr)
        REG_SRC_LO: src_lo <= cfg_req_wdata;
        REG_SRC_HI: src_hi <= cfg_req_wdata;
        REG_DST_LO: dst_lo <= cfg_req_wdata;
        REG_DST_HI: dst_hi <= cfg_req_wdata;
        REG_LEN:    len_q  <= cfg_req_wdata;
        REG_CTRL:   irq_en <= cfg_req_wdata[0];
        default:    ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (doorbell && fifo_full && !fifo_pop) begin
      overflow <= 1'b1;
    end else if (wr_en && (cfg_req_addr == REG_STATUS) && cfg_req_wdata[3]) begin
      overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_cnt <= '0;
    end else if (done_clr) begin
      done_cnt <= done_inc ? 32'd1 : '0;
    end else if (done_inc && (done_cnt != '1)) begin
      done_cnt <= done_cnt + 32'd1;
    end
  end

  assign irq = irq_en && (done_cnt != '0);

  always_comb begin
    rdata_nxt = '0;
    case (cfg_req_addr)
      REG_SRC_LO:   rdata_nxt = src_lo;
      REG_SRC_HI:   rdata_nxt = src_hi;
      REG_DST_LO:   rdata_nxt = dst_lo;
      REG_DST_HI:   rdata_nxt = dst_hi;
      REG_LEN:      rdata_nxt = len_q;
      REG_STATUS:   rdata_nxt = {16'b0, 8'(fifo_count), 4'b0, overflow,
                                 fifo_full, fifo_empty, state != ST_IDLE};
      REG_DONE_CNT: rdata_nxt = done_cnt;
      REG_CTRL:     rdata_nxt = {31'b0, irq_en};
      default:      rdata_nxt = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_resp_valid <= 1'b0;
      cfg_resp_rdata <= '0;
    end else begin
      cfg_resp_valid <= cfg_req_valid;
      cfg_resp_rdata <= rd_en ? rdata_nxt : '0;
    end
  end

endmodule

// File: tb/tb_dma_desc_queue.sv
// Bench for dma_desc_queue: directed scenarios plus a randomized MMIO phase, checked
// against a queue-based model of accepted descriptors and completion counts.
module tb_dma_desc_queue;
  import dma_pkg::*;

  localparam int unsigned DEPTH      = 4;
  localparam int unsigned ADDR_WIDTH = 48;
  localparam logic [63:0] AMASK      = 64'h0000_FFFF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_req_valid = 1'b0;
  logic        cfg_req_write = 1'b0;
  logic [31:0] cfg_req_addr = '0;
  logic [31:0] cfg_req_wdata = '0;
  logic        cfg_resp_valid;
  logic [31:0] cfg_resp_rdata;
  logic        dma_start;
  logic [63:0] dma_src_addr;
  logic [63:0] dma_dst_addr;
  logic [31:0] dma_len;
  logic        dma_done = 1'b0;
  logic        irq;

  always #5 clk = ~clk;

  dma_desc_queue #(.DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cfg_req_valid (cfg_req_valid),
    .cfg_req_write (cfg_req_write),
    .cfg_req_addr  (cfg_req_addr),
    .cfg_req_wdata (cfg_req_wdata),
    .cfg_resp_valid(cfg_resp_valid),
    .cfg_resp_rdata(cfg_resp_rdata),
    .dma_start     (dma_start),
    .dma_src_addr  (dma_src_addr),
    .dma_dst_addr  (dma_dst_addr),
    .dma_len       (dma_len),
    .dma_done      (dma_done),
    .irq           (irq)
  );

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model: staging mirror, descriptors expected to reach the engine in order,
  // accepted-descriptor completion count, sticky overflow and IRQ enable.
  logic [31:0] stg [5];
  desc_t       exp_starts [$];
  int unsigned m_done = 0;
  bit          m_ovf = 1'b0;
  bit          m_irq_en = 1'b0;

  function automatic logic [31:0] status_exp(input bit busy);
    int unsigned n;
    n = exp_starts.size();
    return {16'h0, 8'(n), 4'h0, m_ovf, n == DEPTH, n == 0, busy};
  endfunction

  // Engine stand-in: checks each start against the model, completes after a short
  // random delay unless stalled, and throws stray done pulses while no transfer is open.
  desc_t       cur, e_mon;
  int unsigned start_cnt = 0;
  int unsigned last_start_cyc = 0;
  int unsigned done_wait = 0;
  bit          outstanding = 1'b0;
  bit          stall = 1'b0;
  bit          spurious_en = 1'b0;

  always @(negedge clk) begin
    dma_done = 1'b0;
    if (!rst_n) begin
      outstanding = 1'b0;
    end else if (dma_start) begin
      start_cnt++;
      last_start_cyc = cyc;
      cur.src = dma_src_addr;
      cur.dst = dma_dst_addr;
      cur.len = dma_len;
      if (exp_starts.size() == 0) begin
        check_eq("start_expected", 64'(exp_starts.size()), 64'd1);
      end else begin
        e_mon = exp_starts.pop_front();
        check_eq("start_src", dma_src_addr, e_mon.src);
        check_eq("start_dst", dma_dst_addr, e_mon.dst);
        check_eq("start_len", 64'(dma_len), 64'(e_mon.len));
      end
      outstanding = 1'b1;
      done_wait = $urandom_range(0, 3);
    end else if (outstanding) begin
      if (!stall) begin
        if (done_wait == 0) begin
          check_eq("hold_src", dma_src_addr, cur.src);
          check_eq("hold_len", 64'(dma_len), 64'(cur.len));
          dma_done = 1'b1;
          outstanding = 1'b0;
        end else begin
          done_wait--;
        end
      end
    end else if (spurious_en && $urandom_range(0, 5) == 0) begin
      dma_done = 1'b1;
    end
  end

  int unsigned req_cyc = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mmio_write(input logic [31:0] a, input logic [31:0] d);
    cfg_req_valid = 1'b1;
    cfg_req_write = 1'b1;
    cfg_req_addr  = a;
    cfg_req_wdata = d;
    req_cyc = cyc;
    tick();
    cfg_req_valid = 1'b0;
    cfg_req_write = 1'b0;
    check_eq("wr_ack", 64'(cfg_resp_valid), 64'd1);
    check_eq("wr_rdata", 64'(cfg_resp_rdata), 64'd0);
  endtask

  task automatic mmio_read(input logic [31:0] a, output logic [31:0] d);
    cfg_req_valid = 1'b1;
    cfg_req_write = 1'b0;
    cfg_req_addr  = a;
    tick();
    cfg_req_valid = 1'b0;
    check_eq("rd_ack", 64'(cfg_resp_valid), 64'd1);
    d = cfg_resp_rdata;
  endtask

  task automatic read_expect(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    mmio_read(a, d);
    check_eq(tag, 64'(d), 64'(exp));
  endtask

  task automatic stg_write(input int unsigned idx, input logic [31:0] v);
    stg[idx] = v;
    mmio_write(32'(32'h10 + idx * 4), v);
  endtask

  task automatic doorbell(input bit may_drop);
    desc_t d;
    d.src = {stg[1], stg[0]} & AMASK;
    d.dst = {stg[3], stg[2]} & AMASK;
    d.len = stg[4];
    if (may_drop && exp_starts.size() >= DEPTH) begin
      m_ovf = 1'b1;
    end else begin
      if (d.len != 0) exp_starts.push_back(d);
      m_done++;
    end
    mmio_write(REG_DOORBELL, $urandom);
  endtask

  task automatic clear_done();
    mmio_write(REG_DONE_CNT, $urandom);
    m_done = 0;
  endtask

  task automatic wait_start(input int unsigned target);
    int unsigned n;
    n = 0;
    while (start_cnt < target && n < 50) begin
      tick();
      n++;
    end
    check_eq("start_seen", 64'(start_cnt), 64'(target));
  endtask

  task automatic wait_drain();
    logic [31:0] st;
    int unsigned n;
    n = 0;
    stall = 1'b0;
    do begin
      mmio_read(REG_STATUS, st);
      n++;
    end while (st[1:0] != 2'b10 && n < 300);
    check_eq("drain_status", 64'(st[1:0]), 64'd2);
    check_eq("drain_pending", 64'(exp_starts.size()), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_start"}, 64'(dma_start), 64'd0);
    check_eq({tag, "_src"}, dma_src_addr, 64'd0);
    check_eq({tag, "_dst"}, dma_dst_addr, 64'd0);
    check_eq({tag, "_len"}, 64'(dma_len), 64'd0);
    check_eq({tag, "_irq"}, 64'(irq), 64'd0);
    check_eq({tag, "_resp"}, 64'(cfg_resp_valid), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded its time budget at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned base, db_cyc, op, idx;
    logic [31:0] v, st;

    for (int i = 0; i < 5; i++) stg[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("por");
    rst_n = 1'b1;
    tick();
    read_expect("status_reset", REG_STATUS, status_exp(1'b0));
    read_expect("unmapped_rd", 32'h34, 32'h0);
    read_expect("doorbell_rd", REG_DOORBELL, 32'h0);

    // Basic transfer and start latency.
    stall = 1'b1;
    stg_write(0, 32'h1000);
    stg_write(1, 32'h0);
    stg_write(2, 32'h2000);
    stg_write(3, 32'h0);
    stg_write(4, 32'd64);
    base = start_cnt;
    doorbell(1'b0);
    db_cyc = req_cyc;
    wait_start(base + 1);
    check_eq("start_latency", 64'(last_start_cyc - db_cyc), 64'd2);
    read_expect("status_busy", REG_STATUS, status_exp(1'b1));
    read_expect("staging_kept", REG_SRC_LO, 32'h1000);
    wait_drain();
    read_expect("done_cnt_t1", REG_DONE_CNT, m_done);
    read_expect("status_idle", REG_STATUS, status_exp(1'b0));

    // Overflow with the engine stalled.
    clear_done();
    stall = 1'b1;
    stg_write(4, 32'($urandom_range(1, 4096)));
    base = start_cnt;
    doorbell(1'b1);
    wait_start(base + 1);
    for (int i = 0; i < 5; i++) begin
      stg_write(0, $urandom);
      stg_write(4, 32'($urandom_range(1, 4096)));
      doorbell(1'b1);
    end
    repeat (3) tick();
    check_eq("t2_starts", 64'(start_cnt - base), 64'd1);
    read_expect("status_full_ovf", REG_STATUS, status_exp(1'b1));
    mmio_write(REG_STATUS, 32'h8);
    m_ovf = 1'b0;
    read_expect("status_ovf_clr", REG_STATUS, status_exp(1'b1));
    wait_drain();
    read_expect("done_cnt_t2", REG_DONE_CNT, m_done);

    // Zero-length descriptor is retired without a start.
    clear_done();
    stall = 1'b1;
    stg_write(4, 32'd0);
    base = start_cnt;
    doorbell(1'b1);
    repeat (4) tick();
    check_eq("zero_len_nostart", 64'(start_cnt - base), 64'd0);
    read_expect("done_cnt_zero", REG_DONE_CNT, m_done);
    stg_write(4, 32'd16);
    doorbell(1'b1);
    wait_start(base + 1);
    check_eq("len16", 64'(dma_len), 64'd16);
    wait_drain();
    read_expect("done_cnt_t3", REG_DONE_CNT, m_done);

    // Interrupt raise and clear.
    clear_done();
    mmio_write(REG_CTRL, 32'h1);
    m_irq_en = 1'b1;
    check_eq("irq_idle", 64'(irq), 64'(m_irq_en && m_done != 0));
    stg_write(4, 32'd8);
    doorbell(1'b1);
    wait_drain();
    check_eq("irq_set", 64'(irq), 64'(m_irq_en && m_done != 0));
    clear_done();
    check_eq("irq_clr", 64'(irq), 64'(m_irq_en && m_done != 0));

    // Reset in the middle of a transfer with descriptors queued.
    stall = 1'b1;
    base = start_cnt;
    for (int i = 0; i < 3; i++) begin
      stg_write(4, 32'($urandom_range(1, 256)));
      doorbell(1'b1);
    end
    wait_start(base + 1);
    repeat (3) tick();
    read_expect("status_q2", REG_STATUS, status_exp(1'b1));
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    exp_starts.delete();
    for (int i = 0; i < 5; i++) stg[i] = '0;
    m_done = 0;
    m_ovf = 1'b0;
    m_irq_en = 1'b0;
    base = start_cnt;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    stall = 1'b0;
    tick();
    read_expect("status_post_rst", REG_STATUS, status_exp(1'b0));
    read_expect("len_post_rst", REG_LEN, stg[4]);
    read_expect("ctrl_post_rst", REG_CTRL, 32'(m_irq_en));
    repeat (10) tick();
    check_eq("no_start_post_rst", 64'(start_cnt - base), 64'd0);

    // Randomized MMIO traffic with stray done pulses.
    spurious_en = 1'b1;
    clear_done();
    for (int i = 0; i < 300; i++) begin
      op = $urandom_range(0, 9);
      if (op <= 2) begin
        idx = $urandom_range(0, 4);
        v = $urandom;
        if (idx == 4 && $urandom_range(0, 3) == 0) v = '0;
        stg_write(idx, v);
      end else if (op <= 4) begin
        idx = $urandom_range(0, 4);
        read_expect("stg_readback", 32'(32'h10 + idx * 4), stg[idx]);
      end else if (op <= 7) begin
        mmio_read(REG_STATUS, st);
        if (!st[2]) doorbell(1'b0);
      end else if (op == 8) begin
        m_irq_en = 1'($urandom_range(0, 1));
        mmio_write(REG_CTRL, {$urandom_range(0, 65535), 15'h0, m_irq_en});
        read_expect("ctrl_readback", REG_CTRL, 32'(m_irq_en));
      end else begin
        tick();
      end
    end
    wait_drain();
    spurious_en = 1'b0;
    read_expect("done_cnt_rand", REG_DONE_CNT, m_done);
    read_expect("status_rand", REG_STATUS, status_exp(1'b0));
    check_eq("irq_rand", 64'(irq), 64'(m_irq_en && m_done != 0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dma_desc_queue.md
DMA_DESC_QUEUE -- requirements
Module: dma_desc_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of queued descriptors; power of two, minimum 2.
REQ-002 Parameter ADDR_WIDTH, default 48, significant address bits forwarded to the DMA; upper bits of the 64-bit fields are driven 0.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 cfg_req_valid  input  1  MMIO request strobe, one cycle per request.
REQ-006 cfg_req_write  input  1  1 = write, 0 = read.
REQ-007 cfg_req_addr  input  32  register byte offset.
REQ-008 cfg_req_wdata  input  32  write data.
REQ-009 cfg_resp_valid  output  1  read/write acknowledge.
REQ-010 cfg_resp_rdata  output  32  read data; 0 for writes and unmapped offsets.
REQ-011 dma_start  output  1  one-cycle start pulse to DMA engine.
REQ-012 dma_src_addr / dma_dst_addr  output  64 each  descriptor addresses, stable from dma_start until dma_done.
REQ-013 dma_len  output  32  descriptor byte length, same stability rule.
REQ-014 dma_done  input  1  DMA completion; sampled only in WAIT.
REQ-015 irq  output  1  level interrupt, high while DONE_CNT != 0 and IRQ_EN = 1.

Function
REQ-016 Register map: 0x10 SRC_LO, 0x14 SRC_HI, 0x18 DST_LO, 0x1C DST_HI, 0x20 LEN (all R/W staging registers); 0x24 DOORBELL (write-only); 0x28 STATUS (RO); 0x2C DONE_CNT (R, write-any clears); 0x30 CTRL (bit0 IRQ_EN, R/W).
REQ-017 STATUS = {16'b0, count[7:0], 4'b0, overflow, full, empty, busy}; busy = FSM not IDLE.
REQ-018 cfg_resp_valid asserts exactly one cycle after every cfg_req_valid; rdata registered, captured from state at request cycle.
REQ-019 DOORBELL write pushes {SRC, DST, LEN} staging contents into the FIFO; the staging registers retain their values.
REQ-020 DOORBELL when full: descriptor dropped, sticky overflow set; overflow clears only by writing 1 to STATUS bit3.
REQ-021 Simultaneous push and pop in one cycle: both occur, count unchanged; push while full and pop in the same cycle is accepted.
REQ-022 FSM states IDLE, ISSUE, WAIT; IDLE -> ISSUE when FIFO non-empty (pop head into output registers); ISSUE -> WAIT with dma_start = 1 for that cycle only; WAIT -> IDLE on dma_done = 1.
REQ-023 Popped descriptor with LEN = 0 is retired in IDLE without dma_start; DONE_CNT increments; FSM stays IDLE.
REQ-024 Latency: DOORBELL in cycle N with FIFO empty and FSM IDLE gives dma_start in cycle N+2.
REQ-025 DONE_CNT increments on each completion, saturating at 0xFFFF_FFFF; a clear and an increment in the same cycle yields 1.
REQ-026 Write pointers wrap modulo DEPTH; count width = clog2(DEPTH)+1.
REQ-027 dma_done outside WAIT is ignored.

Reset
REQ-028 On rst_n low: FIFO empty, pointers 0, FSM IDLE, staging/output/DONE_CNT/CTRL/overflow 0, dma_start 0, cfg_resp_valid 0, irq 0; applies immediately, including mid-transfer (in-flight descriptor discarded).

Structure
REQ-029 Package dma_pkg SHALL hold desc_t struct {src, dst, len}, register offset localparams and the FSM state enum.
REQ-030 Sub-module sync_fifo (parameterised width/depth, full/empty/count) SHALL implement descriptor storage.

Verification
REQ-031 SRC=0x1000, DST=0x2000, LEN=64, DOORBELL at cycle N -> dma_start at N+2 with those values; dma_done -> DONE_CNT=1, STATUS.busy=0.
REQ-032 Six DOORBELLs with DMA stalled, DEPTH=4 -> first descriptor issued, 4 queued, 1 dropped, STATUS.full=1, overflow=1.
REQ-033 LEN=0 descriptor followed by LEN=16 -> no start for first, DONE_CNT=1, then one start with LEN=16.
REQ-034 IRQ_EN=1, one completion -> irq=1; write DONE_CNT -> irq=0 next cycle.
REQ-035 rst_n low during WAIT with 2 queued -> all outputs 0, STATUS.empty=1 after release, no dma_start.
